// File: rtl/serial_display_driver_if.sv
// Bus bundle for the serial 7-segment display driver: frame request/control
// inputs and the serial chain outputs.
interface serial_display_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic                      enable;
    logic                      cont;
    logic                      start;
    logic                      blank_lz;
    logic [4*NUM_DIGITS-1:0]   bcd_in;
    logic [NUM_DIGITS-1:0]     dp_in;
    logic                      ser_data;
    logic                      ser_clk;
    logic                      ser_latch;
    logic                      busy;
    logic                      frame_done;

    // Result path / controller side
    modport master (
        output enable, cont, start, blank_lz, bcd_in, dp_in,
        input  ser_data, ser_clk, ser_latch, busy, frame_done
    );

    // Display driver side
    modport slave (
        input  enable, cont, start, blank_lz, bcd_in, dp_in,
        output ser_data, ser_clk, ser_latch, busy, frame_done
    );
endinterface

// File: rtl/serial_display_driver.sv
// Serial driver for chained shift-register 7-segment displays. Encodes BCD
// digits (with leading-zero blanking and decimal points) into segment bytes
// and shifts the frame out with a generated serial clock and latch strobe.
module serial_display_driver #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned CLK_DIV    = 1,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned LSB_FIRST  = 1
) (
    input logic                    clk,
    input logic                    rst,
    serial_display_driver_if.slave bus
);
    localparam int unsigned FRAME_BITS = 8 * NUM_DIGITS;
    localparam int unsigned DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W      = $clog2(FRAME_BITS);
    localparam int unsigned GAP_W      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StShift, StLatch, StGap} state_e;

    state_e                  state_q;
    logic [FRAME_BITS-1:0]   sr_q;
    logic [DIV_W-1:0]        div_q;
    logic                    half_q;
    logic [BIT_W-1:0]        bit_q;
    logic [GAP_W-1:0]        gap_q;
    logic                    ser_data_q;
    logic                    ser_clk_q;
    logic                    ser_latch_q;
    logic                    busy_q;
    logic                    done_q;

    logic [FRAME_BITS-1:0]   frame_ordered;
    logic                    div_last;
    logic                    bit_last;
    logic                    gap_last;
    logic                    frame_end;
    logic                    load;

    // Encode digits into segment bytes, laid out in transmit order (bit 0 goes out first)
    always_comb begin : encode
        logic       run;
        logic [3:0] nib;
        logic [7:0] seg;
        int         slot;
        run           = 1'b1;
        frame_ordered = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nib = bcd_in_nib(i);
            // Leading-zero run ends at the first non-zero (or dash) digit; digit 0 never blanks
            if (i == 0 || nib != 4'd0) run = 1'b0;
            case (nib)
                4'd0:    seg = 8'hFC;
                4'd1:    seg = 8'h60;
                4'd2:    seg = 8'hDA;
                4'd3:    seg = 8'hF2;
                4'd4:    seg = 8'h66;
                4'd5:    seg = 8'hB6;
                4'd6:    seg = 8'hBE;
                4'd7:    seg = 8'hE0;
                4'd8:    seg = 8'hFE;
                4'd9:    seg = 8'hF6;
                default: seg = 8'h02;
            endcase
            if (run && bus.blank_lz) seg = 8'h00;
            seg[0] = seg[0] | bus.dp_in[i];
            slot = NUM_DIGITS - 1 - i;
            for (int j = 0; j < 8; j++) begin
                frame_ordered[8*slot+j] = (LSB_FIRST != 0) ? seg[j] : seg[7-j];
            end
        end
    end

    function automatic logic [3:0] bcd_in_nib(input int idx);
        return bus.bcd_in[4*idx +: 4];
    endfunction

    // Counter terminal conditions and frame (re)load decision
    always_comb begin
        div_last  = (div_q == DIV_W'(CLK_DIV - 1));
        bit_last  = (bit_q == BIT_W'(FRAME_BITS - 1));
        gap_last  = (gap_q == GAP_W'(GAP_CYCLES - 1));
        frame_end = (state_q == StLatch && div_last && GAP_CYCLES == 0) ||
                    (state_q == StGap && gap_last);
        load      = (state_q == StIdle && (bus.cont || bus.start)) || (frame_end && bus.cont);
    end

    // Frame sequencer with registered serial outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            sr_q        <= '0;
            div_q       <= '0;
            half_q      <= 1'b0;
            bit_q       <= '0;
            gap_q       <= '0;
            ser_data_q  <= 1'b0;
            ser_clk_q   <= 1'b0;
            ser_latch_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (bus.enable) begin
            if (load) begin
                // Snapshot the frame and present its first bit immediately
                state_q     <= StShift;
                sr_q        <= frame_ordered >> 1;
                ser_data_q  <= frame_ordered[0];
                ser_clk_q   <= 1'b0;
                ser_latch_q <= 1'b0;
                busy_q      <= 1'b1;
                done_q      <= 1'b0;
                div_q       <= '0;
                half_q      <= 1'b0;
                bit_q       <= '0;
                gap_q       <= '0;
            end else begin
                unique case (state_q)
                    StIdle: ;
                    StShift: begin
                        if (!div_last) begin
                            div_q <= div_q + 1'b1;
                        end else begin
                            div_q <= '0;
                            if (!half_q) begin
                                half_q    <= 1'b1;
                                ser_clk_q <= 1'b1;
                            end else if (bit_last) begin
                                state_q     <= StLatch;
                                half_q      <= 1'b0;
                                ser_clk_q   <= 1'b0;
                                ser_data_q  <= 1'b0;
                                ser_latch_q <= 1'b1;
                                done_q      <= (CLK_DIV == 1);
                            end else begin
                                // Falling edge of ser_clk: advance to the next bit
                                half_q     <= 1'b0;
                                ser_clk_q  <= 1'b0;
                                bit_q      <= bit_q + 1'b1;
                                ser_data_q <= sr_q[0];
                                sr_q       <= sr_q >> 1;
                            end
                        end
                    end
                    StLatch: begin
                        if (!div_last) begin
                            div_q  <= div_q + 1'b1;
                            done_q <= (div_q == DIV_W'(CLK_DIV - 2));
                        end else begin
                            div_q       <= '0;
                            ser_latch_q <= 1'b0;
                            done_q      <= 1'b0;
                            if (GAP_CYCLES > 0) begin
                                state_q <= StGap;
                                gap_q   <= '0;
                            end else begin
                                state_q <= StIdle;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    StGap: begin
                        if (!gap_last) begin
                            gap_q <= gap_q + 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.ser_data   = ser_data_q;
    assign bus.ser_clk    = ser_clk_q;
    assign bus.ser_latch  = ser_latch_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_serial_display_driver.sv
// Bench for serial_display_driver: three instances (default, MSB-first with
// CLK_DIV=2, continuous with a gap), table vectors, random frames against a
// reference encoder, and hand-written reset / enable / continuous sequences.
module tb_serial_display_driver;
    bit clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        rst_s    [3];
    logic        en_s     [3];
    logic        cont_s   [3];
    logic        start_s  [3];
    logic        blank_s  [3];
    logic [15:0] bcd_s    [3];
    logic [3:0]  dp_s     [3];
    logic        sd [3];
    logic        sc [3];
    logic        sl [3];
    logic        bz [3];
    logic        fd [3];

    serial_display_driver_if #(.NUM_DIGITS(4)) if_a ();
    serial_display_driver_if #(.NUM_DIGITS(4)) if_b ();
    serial_display_driver_if #(.NUM_DIGITS(4)) if_c ();

    serial_display_driver #(.NUM_DIGITS(4), .CLK_DIV(1), .GAP_CYCLES(0), .LSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst_s[0]), .bus(if_a)
    );
    serial_display_driver #(.NUM_DIGITS(4), .CLK_DIV(2), .GAP_CYCLES(0), .LSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst_s[1]), .bus(if_b)
    );
    serial_display_driver #(.NUM_DIGITS(4), .CLK_DIV(1), .GAP_CYCLES(3), .LSB_FIRST(1)) dut_c (
        .clk(clk), .rst(rst_s[2]), .bus(if_c)
    );

    assign if_a.enable = en_s[0];   assign if_b.enable = en_s[1];   assign if_c.enable = en_s[2];
    assign if_a.cont = cont_s[0];   assign if_b.cont = cont_s[1];   assign if_c.cont = cont_s[2];
    assign if_a.start = start_s[0]; assign if_b.start = start_s[1]; assign if_c.start = start_s[2];
    assign if_a.blank_lz = blank_s[0];
    assign if_b.blank_lz = blank_s[1];
    assign if_c.blank_lz = blank_s[2];
    assign if_a.bcd_in = bcd_s[0];  assign if_b.bcd_in = bcd_s[1];  assign if_c.bcd_in = bcd_s[2];
    assign if_a.dp_in = dp_s[0];    assign if_b.dp_in = dp_s[1];    assign if_c.dp_in = dp_s[2];
    assign sd[0] = if_a.ser_data;   assign sd[1] = if_b.ser_data;   assign sd[2] = if_c.ser_data;
    assign sc[0] = if_a.ser_clk;    assign sc[1] = if_b.ser_clk;    assign sc[2] = if_c.ser_clk;
    assign sl[0] = if_a.ser_latch;  assign sl[1] = if_b.ser_latch;  assign sl[2] = if_c.ser_latch;
    assign bz[0] = if_a.busy;       assign bz[1] = if_b.busy;       assign bz[2] = if_c.busy;
    assign fd[0] = if_a.frame_done; assign fd[1] = if_b.frame_done; assign fd[2] = if_c.frame_done;

    // Monitor: running counts of serial bits (captured at ser_clk rise), latch/busy cycles, pulses
    int cyc = 0;
    bit sc_prev   [3];
    bit cap_bits  [3][2048];
    int rise_cyc  [3][2048];
    int cap_n     [3];
    int latch_cyc [3];
    int busy_cyc  [3];
    int done_cnt  [3];
    int done_cyc  [3][64];

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (sc[k] && !sc_prev[k]) begin
                cap_bits[k][cap_n[k] % 2048] <= sd[k];
                rise_cyc[k][cap_n[k] % 2048] <= cyc;
                cap_n[k] <= cap_n[k] + 1;
            end
            sc_prev[k] <= sc[k];
            if (sl[k]) latch_cyc[k] <= latch_cyc[k] + 1;
            if (bz[k]) busy_cyc[k] <= busy_cyc[k] + 1;
            if (fd[k]) begin
                done_cyc[k][done_cnt[k] % 64] <= cyc;
                done_cnt[k] <= done_cnt[k] + 1;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Reference encoder: segment bytes in send order, first byte in [31:24]
    function automatic logic [31:0] model_frame(input logic [15:0] bcd, input logic [3:0] dp,
                                                input bit blank);
        logic [7:0] table_seg [10];
        logic [31:0] out;
        bit lead;
        int d;
        logic [7:0] s;
        table_seg = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
        lead = 1'b1;
        out  = '0;
        for (int i = 3; i >= 0; i--) begin
            d = int'(bcd >> (4 * i)) % 16;
            if (i == 0 || d != 0) lead = 1'b0;
            s = (d > 9) ? 8'h02 : table_seg[d];
            if (lead && blank) s = 8'h00;
            if (dp[i]) s = s | 8'h01;
            out[8*i +: 8] = s;
        end
        return out;
    endfunction

    function automatic bit exp_bit(input logic [31:0] bytes, input int n, input bit lsb);
        logic [7:0] b;
        b = bytes[31 - 8*(n/8) -: 8];
        return lsb ? b[n % 8] : b[7 - n % 8];
    endfunction

    task automatic chk_bits(input int k, input int base, input logic [31:0] bytes,
                            input bit lsb, input string name);
        logic [31:0] act;
        logic [31:0] exp;
        for (int n = 0; n < 32; n++) begin
            act[31-n] = cap_bits[k][(base + n) % 2048];
            exp[31-n] = exp_bit(bytes, n, lsb);
        end
        chk(name, act, exp);
    endtask

    // One-shot frame: start pulse, wait for completion, check bits and timing
    task automatic run_oneshot(input int k, input int cd, input bit lsb, input logic [15:0] bcd,
                               input logic [3:0] dp, input bit blank, input logic [31:0] bytes,
                               input string name);
        int b0, l0, d0, y0, r0;
        bcd_s[k] = bcd; dp_s[k] = dp; blank_s[k] = blank;
        b0 = cap_n[k]; l0 = latch_cyc[k]; d0 = done_cnt[k]; y0 = busy_cyc[k];
        start_s[k] = 1'b1;
        step(1);
        start_s[k] = 1'b0;
        chk({name, " busy_after_start"}, 32'(bz[k]), 32'd1);
        for (int i = 0; i < 1000 && bz[k]; i++) step(1);
        chk({name, " busy_end"}, 32'(bz[k]), 32'd0);
        chk({name, " bit_count"}, 32'(cap_n[k] - b0), 32'd32);
        chk_bits(k, b0, bytes, lsb, {name, " bits"});
        chk({name, " latch_cycles"}, 32'(latch_cyc[k] - l0), 32'(cd));
        chk({name, " done_pulses"}, 32'(done_cnt[k] - d0), 32'd1);
        chk({name, " busy_cycles"}, 32'(busy_cyc[k] - y0), 32'(16 * 4 * cd + cd));
        r0 = rise_cyc[k][(b0 + 1) % 2048] - rise_cyc[k][b0 % 2048];
        chk({name, " clk_period"}, 32'(r0), 32'(2 * cd));
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        bit          blank;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int b0, l0, d0, y0, changes;
        logic sc0, sd0;
        logic [15:0] rb;
        logic [3:0]  rd;
        bit          rl;

        tbl[0] = '{16'h1234, 4'b0000, 1'b0, 32'h60DAF266};
        tbl[1] = '{16'h0000, 4'b0100, 1'b1, 32'h000100FC};
        tbl[2] = '{16'h0A05, 4'b0000, 1'b1, 32'h0002FCB6};
        tbl[3] = '{16'h0008, 4'b0000, 1'b1, 32'h000000FE};
        tbl[4] = '{16'h0000, 4'b0000, 1'b0, 32'hFCFCFCFC};
        tbl[5] = '{16'hF9E0, 4'b1111, 1'b1, 32'h03F703FD};
        tbl[6] = '{16'h0070, 4'b0001, 1'b0, 32'hFCFCE0FD};

        for (int k = 0; k < 3; k++) begin
            rst_s[k] = 1'b1; en_s[k] = 1'b1; cont_s[k] = 1'b0; start_s[k] = 1'b0;
            blank_s[k] = 1'b0; bcd_s[k] = '0; dp_s[k] = '0;
        end
        step(3);
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        step(2);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_outputs%0d", k), 32'({sd[k], sc[k], sl[k], bz[k], fd[k]}), 32'd0);
        end

        // Table vectors on the LSB-first and MSB-first instances
        for (int t = 0; t < 7; t++) begin
            run_oneshot(0, 1, 1'b1, tbl[t].bcd, tbl[t].dp, tbl[t].blank, tbl[t].exp,
                        $sformatf("tblA%0d", t));
            run_oneshot(1, 2, 1'b0, tbl[t].bcd, tbl[t].dp, tbl[t].blank, tbl[t].exp,
                        $sformatf("tblB%0d", t));
        end

        // Random frames against the reference encoder
        for (int t = 0; t < 20; t++) begin
            rb = 16'($urandom);
            rd = 4'($urandom);
            rl = 1'($urandom);
            run_oneshot(0, 1, 1'b1, rb, rd, rl, model_frame(rb, rd, rl), $sformatf("rnd%0d", t));
        end

        // Enable held low mid-frame, plus a start request while busy
        bcd_s[0] = 16'h5678; dp_s[0] = 4'b0010; blank_s[0] = 1'b0;
        b0 = cap_n[0]; d0 = done_cnt[0]; y0 = busy_cyc[0];
        start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        step(20);
        sc0 = sc[0]; sd0 = sd[0];
        en_s[0] = 1'b0;
        changes = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (sc[0] !== sc0 || sd[0] !== sd0) changes++;
        end
        en_s[0] = 1'b1;
        step(10);
        start_s[0] = 1'b1;
        step(1);
        start_s[0] = 1'b0;
        for (int i = 0; i < 1000 && bz[0]; i++) step(1);
        chk("en_frozen_changes", 32'(changes), 32'd0);
        chk("en_busy_cycles", 32'(busy_cyc[0] - y0), 32'd70);
        chk("en_bit_count", 32'(cap_n[0] - b0), 32'd32);
        chk_bits(0, b0, model_frame(16'h5678, 4'b0010, 1'b0), 1'b1, "en_bits");
        chk("en_done", 32'(done_cnt[0] - d0), 32'd1);
        step(5);
        chk("start_while_busy_ignored", 32'(bz[0]), 32'd0);

        // Asynchronous reset during bit 10 of a continuous frame
        bcd_s[0] = 16'h9021; dp_s[0] = 4'b0010; blank_s[0] = 1'b1;
        b0 = cap_n[0]; l0 = latch_cyc[0]; d0 = done_cnt[0];
        cont_s[0] = 1'b1;
        for (int i = 0; i < 200 && (cap_n[0] - b0) < 11; i++) step(1);
        rst_s[0] = 1'b1;
        #1;
        chk("rst_async_outputs", 32'({sd[0], sc[0], sl[0], bz[0], fd[0]}), 32'd0);
        chk("rst_no_latch", 32'(latch_cyc[0] - l0), 32'd0);
        chk("rst_no_done", 32'(done_cnt[0] - d0), 32'd0);
        step(2);
        rst_s[0] = 1'b0;
        b0 = cap_n[0]; l0 = latch_cyc[0]; d0 = done_cnt[0];
        for (int i = 0; i < 300 && done_cnt[0] == d0; i++) step(1);
        cont_s[0] = 1'b0;
        chk_bits(0, b0, model_frame(16'h9021, 4'b0010, 1'b1), 1'b1, "rst_fresh_bits");
        chk("rst_fresh_latch", 32'(latch_cyc[0] - l0), 32'd1);
        for (int i = 0; i < 300 && bz[0]; i++) step(1);
        chk("rst_idle_after", 32'(bz[0]), 32'd0);

        // Continuous refresh with a 3-cycle gap; mid-frame data change and cont drop
        bcd_s[2] = 16'h4321; dp_s[2] = 4'b0000; blank_s[2] = 1'b0;
        b0 = cap_n[2]; d0 = done_cnt[2];
        cont_s[2] = 1'b1;
        for (int i = 0; i < 300 && done_cnt[2] - d0 < 1; i++) step(1);
        step(20);
        bcd_s[2] = 16'h8765;
        for (int i = 0; i < 300 && done_cnt[2] - d0 < 2; i++) step(1);
        step(20);
        cont_s[2] = 1'b0;
        for (int i = 0; i < 300 && bz[2]; i++) step(1);
        step(3);
        chk("cont_busy_end", 32'(bz[2]), 32'd0);
        chk("cont_frames", 32'(done_cnt[2] - d0), 32'd3);
        chk("cont_bit_count", 32'(cap_n[2] - b0), 32'd96);
        chk("cont_period1", 32'(done_cyc[2][(d0 + 1) % 64] - done_cyc[2][d0 % 64]), 32'd68);
        chk("cont_period2", 32'(done_cyc[2][(d0 + 2) % 64] - done_cyc[2][(d0 + 1) % 64]), 32'd68);
        chk_bits(2, b0, model_frame(16'h4321, 4'b0000, 1'b0), 1'b1, "cont_frame1");
        chk_bits(2, b0 + 32, model_frame(16'h4321, 4'b0000, 1'b0), 1'b1, "cont_frame2");
        chk_bits(2, b0 + 64, model_frame(16'h8765, 4'b0000, 1'b0), 1'b1, "cont_frame3");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end
endmodule

// File: doc/serial_display_driver.md
Name: serial_display_driver

Overview:
Parametrised serial driver for chained shift-register 7-segment displays. Converts NUM_DIGITS BCD nibbles plus per-digit decimal points into segment bytes, optionally blanks leading zeros, and shifts the frame out with a generated serial clock and latch strobe. Runs in one-shot mode (start/busy handshake) or continuous-refresh mode, and sits between the calculator result path and the off-chip display chain.

Parameters:
NUM_DIGITS, 4, number of digits per frame (1..8); frame length = 8*NUM_DIGITS bits
CLK_DIV, 1, system cycles per ser_clk half-period (>=1)
GAP_CYCLES, 0, idle cycles inserted after the latch pulse before the next frame (0 = none)
LSB_FIRST, 1, 1: segment bit0 shifted first; 0: bit7 shifted first

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
enable  in  1  clock enable; 0 freezes all state and outputs
cont  in  1  1: continuous refresh; 0: one-shot on start
start  in  1  one-shot frame request, sampled in IDLE only
blank_lz  in  1  1: blank leading zero digits
bcd_in  in  4*NUM_DIGITS  digit i = bcd_in[4i+3:4i], digit 0 least significant
dp_in  in  NUM_DIGITS  decimal point per digit
ser_data  out  1  serial segment data
ser_clk  out  1  serial clock; data stable across its rising edge
ser_latch  out  1  latch strobe after the last bit
busy  out  1  high while a frame is in progress (SHIFT, LATCH, GAP)
frame_done  out  1  one-cycle pulse at end of LATCH

Behaviour:
- Reset (async): state IDLE; ser_data, ser_clk, ser_latch, busy, frame_done = 0; counters and frame register cleared. Reset mid-frame aborts immediately; no partial latch is issued.
- enable=0: every register holds, including counters and the pulse outputs.
- Encoding, segment byte {a,b,c,d,e,f,g,dp}, MSB=a: 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6; nibbles A-F = 02 (dash). dp_in[i] sets bit0 of digit i.
- Blanking: when blank_lz=1, the contiguous run of zero digits starting at NUM_DIGITS-1 is encoded as 00, dp still OR'd in. Digit 0 is never blanked. Dash digits stop the run.
- States: IDLE, SHIFT, LATCH, GAP.
- IDLE -> SHIFT on an enabled edge with (cont | start). On that edge the encoded frame is snapshotted, busy=1, and ser_data presents the first bit. bcd_in, dp_in, and blank_lz changes during the frame are ignored.
- Send order: digit NUM_DIGITS-1 first, down to digit 0. Within each byte, bit0..bit7 when LSB_FIRST=1, else bit7..bit0.
- SHIFT: each bit lasts 2*CLK_DIV cycles, ser_clk=0 for the first CLK_DIV cycles and 1 for the second. ser_data changes only on ser_clk falling transitions and at frame start.
- After the high phase of bit 8*NUM_DIGITS-1 -> LATCH: ser_clk=0, ser_data=0, ser_latch=1 for CLK_DIV cycles. frame_done=1 on the last LATCH cycle.
- LATCH -> GAP if GAP_CYCLES>0 (all outputs 0 except busy, for GAP_CYCLES cycles), else handled as GAP end.
- GAP end: cont=1 -> reload directly into SHIFT with no IDLE cycle; cont=0 -> IDLE, busy=0.
- Frame period in cont mode = 16*NUM_DIGITS*CLK_DIV + CLK_DIV + GAP_CYCLES cycles.
- start while busy is ignored, not queued. cont falling mid-frame completes the current frame, then goes to IDLE.
- Counters are sized by $clog2 of their maximum. No wrap-around except the explicit bit/phase counter reloads.

Test Plan:
- Defaults, cont=0, bcd_in=16'h1234, dp_in=0, start pulse -> busy on next edge; first 8 ser_data bits sampled on ser_clk rises = 0,0,0,0,0,1,1,0 (digit 3 '1' = 60h LSB first); 32 bits total, then ser_latch high 1 cycle, frame_done pulse, busy low; total 65 cycles.
- LSB_FIRST=0, CLK_DIV=2, bcd_in=16'h0008, blank_lz=1 -> bytes 00,00,00,FE sent MSB first; ser_clk period 4 cycles; ser_latch high 2 cycles.
- blank_lz=1, bcd_in=16'h0000, dp_in=4'b0100 -> bytes 00,01,00,FC; bcd_in=16'h0A05 -> 00,02,FC,B6 (dash stops blanking).
- cont=1, GAP_CYCLES=3 -> frames back-to-back, 68-cycle period; bcd_in changed mid-frame appears only in the next frame.
- Assert rst mid-SHIFT (bit 10) -> all outputs 0 asynchronously, no ser_latch; after release with cont=1, a full fresh frame follows.
- enable low for 5 cycles mid-frame -> ser_clk/ser_data frozen; frame resumes intact, stretched by exactly 5 cycles; start during busy ignored.
